fejkon_fc_stats: RTL and testbench

- Pass-through Avalon-ST monitor placed directly downstream of the FC debug/generator mux, before the FC transmit path.
- Forwards every 256-bit beat unchanged, with one register stage and a skid buffer so st_in_ready is registered.
- Keeps per-channel packet, byte and framing-error counters, readable and clearable through a CSR slave.

---
 rtl/fejkon_fc_pkg.sv | 29 ++
 rtl/fejkon_fc_stats_if.sv | 15 +
 rtl/fejkon_st_skid.sv | 55 +++++
 rtl/fejkon_fc_stats.sv | 174 +++++++++++++++++
 tb/tb_fejkon_fc_stats.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fejkon_fc_pkg.sv
// Shared types and constants for the FC statistics monitor and its pipeline stage.
package fejkon_fc_pkg;

    localparam int BEAT_BYTES = 32;

    localparam logic [7:0] CSR_CTRL    = 8'h00;
    localparam logic [7:0] CSR_BAD_CH  = 8'h01;
    localparam logic [7:0] CSR_NCH     = 8'h02;
    localparam logic [7:0] CSR_CH_BASE = 8'h10;

    typedef struct packed {
        logic [3:0]   channel;
        logic [255:0] data;
        logic         sop;
        logic         eop;
        logic [4:0]   empty;
    } st_beat_t;

    typedef enum logic {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } framer_state_e;

    // Empty only means something on the EOP beat.
    function automatic logic [5:0] beat_bytes(input logic eop, input logic [4:0] empty);
        return eop ? 6'(BEAT_BYTES) - {1'b0, empty} : 6'(BEAT_BYTES);
    endfunction

endpackage

// File: rtl/fejkon_fc_stats_if.sv
// Avalon-ST beat bundle; master drives the beat, slave drives ready.
interface fejkon_fc_stats_if;
    logic [3:0]   channel;
    logic [255:0] data;
    logic         startofpacket;
    logic         endofpacket;
    logic [4:0]   empty;
    logic         valid;
    logic         ready;

    modport master (output channel, data, startofpacket, endofpacket, empty, valid,
                    input  ready);
    modport slave  (input  channel, data, startofpacket, endofpacket, empty, valid,
                    output ready);
endinterface

// File: rtl/fejkon_st_skid.sv
// Registered-ready pipeline stage: one output register plus one skid entry.
module fejkon_st_skid
    import fejkon_fc_pkg::*;
(
    input  logic     clk,
    input  logic     reset_n,
    input  st_beat_t in_beat,
    input  logic     in_valid,
    output logic     in_ready,
    output st_beat_t out_beat,
    output logic     out_valid,
    input  logic     out_ready
);
    st_beat_t skid_beat;
    logic     skid_valid;
    logic     skid_valid_nx;
    logic     out_free;
    logic     accept;

    // in_ready mirrors !skid_valid, so an accept never coincides with a full skid entry.
    always_comb begin
        out_free      = !out_valid || out_ready;
        accept        = in_valid && in_ready;
        skid_valid_nx = skid_valid;
        if (out_free)
            skid_valid_nx = 1'b0;
        else if (accept)
            skid_valid_nx = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_beat   <= '0;
            out_valid  <= 1'b0;
            skid_beat  <= '0;
            skid_valid <= 1'b0;
            in_ready   <= 1'b0;
        end else begin
            skid_valid <= skid_valid_nx;
            in_ready   <= !skid_valid_nx;
            if (out_free) begin
                if (skid_valid) begin
                    out_beat  <= skid_beat;
                    out_valid <= 1'b1;
                end else begin
                    out_valid <= accept;
                    if (accept)
                        out_beat <= in_beat;
                end
            end else if (accept) begin
                skid_beat <= in_beat;
            end
        end
    end
endmodule

// File: rtl/fejkon_fc_stats.sv
// Pass-through FC stream monitor with per-channel packet/byte/error counters and CSR access.
//   state  | meaning
//   IDLE   | between packets, next legal beat is SOP
//   IN_PKT | inside a packet on cur_ch
module fejkon_fc_stats
    import fejkon_fc_pkg::*;
#(
    parameter int NUM_CHANNELS = 4,
    parameter int CNT_W        = 32,
    parameter int ERR_W        = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    fejkon_fc_stats_if.slave         st_in,
    fejkon_fc_stats_if.master        st_out,
    input  logic [7:0]               csr_address,
    input  logic                     csr_read,
    input  logic                     csr_write,
    input  logic [31:0]              csr_writedata,
    output logic [31:0]              csr_readdata
);
    localparam int CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

    st_beat_t in_beat, out_beat;
    logic     in_ready, out_valid, accept, ch_ok, clr, bad_hit, unused_wdata;
    logic [CH_W-1:0]         ch_idx, cur_idx;
    logic [3:0]              cur_ch, cur_ch_nx;
    logic [5:0]              byte_amt;
    logic [NUM_CHANNELS-1:0] pkt_hit, byte_hit, err_hit;
    framer_state_e           state, state_nx;

    logic [CNT_W-1:0] pkt_cnt  [NUM_CHANNELS];
    logic [CNT_W-1:0] byte_cnt [NUM_CHANNELS];
    logic [ERR_W-1:0] err_cnt  [NUM_CHANNELS];
    logic [ERR_W-1:0] bad_ch;

    logic [7:0]  rd_off;
    logic [5:0]  rd_idx;
    logic [31:0] rd_val;

    assign in_beat.channel = st_in.channel;
    assign in_beat.data    = st_in.data;
    assign in_beat.sop     = st_in.startofpacket;
    assign in_beat.eop     = st_in.endofpacket;
    assign in_beat.empty   = st_in.empty;

    fejkon_st_skid u_skid (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_beat   (in_beat),
        .in_valid  (st_in.valid),
        .in_ready  (in_ready),
        .out_beat  (out_beat),
        .out_valid (out_valid),
        .out_ready (st_out.ready)
    );

    assign st_in.ready          = in_ready;
    assign st_out.valid         = out_valid;
    assign st_out.channel       = out_beat.channel;
    assign st_out.data          = out_beat.data;
    assign st_out.startofpacket = out_beat.sop;
    assign st_out.endofpacket   = out_beat.eop;
    assign st_out.empty         = out_beat.empty;

    assign accept   = st_in.valid && in_ready;
    assign ch_ok    = {28'd0, st_in.channel} < 32'(NUM_CHANNELS);
    assign ch_idx   = st_in.channel[CH_W-1:0];
    assign cur_idx  = cur_ch[CH_W-1:0];
    assign byte_amt = beat_bytes(st_in.endofpacket, st_in.empty);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            cur_ch <= '0;
        end else begin
            state  <= state_nx;
            cur_ch <= cur_ch_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        cur_ch_nx = cur_ch;
        if (accept && ch_ok) begin
            if (st_in.startofpacket) begin
                state_nx  = st_in.endofpacket ? IDLE : IN_PKT;
                cur_ch_nx = st_in.channel;
            end else if (state == IN_PKT && st_in.channel == cur_ch && st_in.endofpacket) begin
                state_nx = IDLE;
            end
        end
    end

    // An SOP inside a packet charges the error to the abandoned channel, then restarts.
    always_comb begin
        pkt_hit  = '0;
        byte_hit = '0;
        err_hit  = '0;
        bad_hit  = accept && !ch_ok;
        if (accept && ch_ok) begin
            if (st_in.startofpacket) begin
                byte_hit[ch_idx] = 1'b1;
                pkt_hit[ch_idx]  = st_in.endofpacket;
                if (state == IN_PKT)
                    err_hit[cur_idx] = 1'b1;
            end else if (state == IN_PKT && st_in.channel == cur_ch) begin
                byte_hit[ch_idx] = 1'b1;
                pkt_hit[ch_idx]  = st_in.endofpacket;
            end else begin
                err_hit[ch_idx] = 1'b1;
            end
        end
    end

    assign clr          = csr_write && csr_address == CSR_CTRL && csr_writedata[0];
    assign unused_wdata = ^csr_writedata[31:1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                pkt_cnt[i]  <= '0;
                byte_cnt[i] <= '0;
                err_cnt[i]  <= '0;
            end
            bad_ch <= '0;
        end else if (clr) begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                pkt_cnt[i]  <= '0;
                byte_cnt[i] <= '0;
                err_cnt[i]  <= '0;
            end
            bad_ch <= '0;
        end else begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                if (pkt_hit[i])
                    pkt_cnt[i] <= pkt_cnt[i] + CNT_W'(1);
                if (byte_hit[i])
                    byte_cnt[i] <= byte_cnt[i] + CNT_W'(byte_amt);
                if (err_hit[i] && err_cnt[i] != '1)
                    err_cnt[i] <= err_cnt[i] + ERR_W'(1);
            end
            if (bad_hit && bad_ch != '1)
                bad_ch <= bad_ch + ERR_W'(1);
        end
    end

    always_comb begin
        rd_off = csr_address - CSR_CH_BASE;
        rd_idx = rd_off[7:2];
        rd_val = '1;
        if (csr_address == CSR_CTRL)
            rd_val = '0;
        else if (csr_address == CSR_BAD_CH)
            rd_val = 32'(bad_ch);
        else if (csr_address == CSR_NCH)
            rd_val = 32'(NUM_CHANNELS);
        else if (csr_address >= CSR_CH_BASE && {2'b00, rd_idx} < 8'(NUM_CHANNELS)) begin
            case (rd_off[1:0])
                2'd0:    rd_val = 32'(pkt_cnt[rd_idx[CH_W-1:0]]);
                2'd1:    rd_val = 32'(byte_cnt[rd_idx[CH_W-1:0]]);
                2'd2:    rd_val = 32'(err_cnt[rd_idx[CH_W-1:0]]);
                default: rd_val = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            csr_readdata <= '0;
        else if (csr_read)
            csr_readdata <= rd_val;
    end
endmodule

// File: tb/tb_fejkon_fc_stats.sv
// Directed scoreboard bench for the FC statistics monitor.
module tb_fejkon_fc_stats;
    import fejkon_fc_pkg::*;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] val;
    } rd_exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  csr_address = '0;
    logic        csr_read = 1'b0;
    logic        csr_write = 1'b0;
    logic [31:0] csr_writedata = '0;
    logic [31:0] csr_readdata;

    fejkon_fc_stats_if st_in_if();
    fejkon_fc_stats_if st_out_if();

    fejkon_fc_stats #(.NUM_CHANNELS(4), .CNT_W(32), .ERR_W(16)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .st_in         (st_in_if),
        .st_out        (st_out_if),
        .csr_address   (csr_address),
        .csr_read      (csr_read),
        .csr_write     (csr_write),
        .csr_writedata (csr_writedata),
        .csr_readdata  (csr_readdata)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          ready_mode = 1;
    int unsigned seq = 0;
    logic        rd_d = 1'b0;
    st_beat_t    exp_q[$];
    rd_exp_t     csr_q[$];
    st_beat_t    mon_got, mon_exp;
    rd_exp_t     rd_exp;

    // 0: hold low, 1: hold high, 2: toggle every cycle
    always @(posedge clk) begin
        #1;
        if (ready_mode == 2)
            st_out_if.ready = ~st_out_if.ready;
        else
            st_out_if.ready = (ready_mode == 1);
    end

    always @(negedge clk) begin
        if (reset_n && st_out_if.valid && st_out_if.ready) begin
            mon_got.channel = st_out_if.channel;
            mon_got.data    = st_out_if.data;
            mon_got.sop     = st_out_if.startofpacket;
            mon_got.eop     = st_out_if.endofpacket;
            mon_got.empty   = st_out_if.empty;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL beat_unexpected: got %h, none expected", mon_got);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_got !== mon_exp) begin
                    errors++;
                    $display("FAIL beat_out: got %h expected %h", mon_got, mon_exp);
                end
            end
        end
    end

    always @(posedge clk) rd_d <= csr_read;

    always @(negedge clk) begin
        if (rd_d) begin
            checks++;
            if (csr_q.size() == 0) begin
                errors++;
                $display("FAIL csr_unexpected: got %h, none expected", csr_readdata);
            end else begin
                rd_exp = csr_q.pop_front();
                if (csr_readdata !== rd_exp.val) begin
                    errors++;
                    $display("FAIL csr_rd addr=%h: got %h expected %h", rd_exp.addr, csr_readdata, rd_exp.val);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        st_in_if.valid = 1'b0;
        repeat (n) tick();
    endtask

    // Entered and left at posedge+1; the beat is accepted on the edge after ready is seen high.
    task automatic send_beat(input logic [3:0] ch, input logic sop, input logic eop, input logic [4:0] emp);
        st_beat_t b;
        int t;
        seq++;
        b.channel = ch;
        b.data    = {8{seq}};
        b.sop     = sop;
        b.eop     = eop;
        b.empty   = emp;
        st_in_if.channel       = b.channel;
        st_in_if.data          = b.data;
        st_in_if.startofpacket = sop;
        st_in_if.endofpacket   = eop;
        st_in_if.empty         = emp;
        st_in_if.valid         = 1'b1;
        t = 0;
        @(negedge clk);
        while (!st_in_if.ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (!st_in_if.ready) begin
            errors++;
            $display("FAIL accept_timeout: ready %0b expected 1", st_in_if.ready);
        end else begin
            exp_q.push_back(b);
        end
        tick();
    endtask

    task automatic csr_rd(input logic [7:0] a, input logic [31:0] exp);
        rd_exp_t r;
        r.addr = a;
        r.val  = exp;
        csr_q.push_back(r);
        csr_address = a;
        csr_read    = 1'b1;
        tick();
        csr_read = 1'b0;
    endtask

    task automatic csr_wr(input logic [7:0] a, input logic [31:0] d);
        csr_address   = a;
        csr_writedata = d;
        csr_write     = 1'b1;
        tick();
        csr_write = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        st_in_if.valid = 1'b0;
        st_in_if.channel = '0;
        st_in_if.data = '0;
        st_in_if.startofpacket = 1'b0;
        st_in_if.endofpacket = 1'b0;
        st_in_if.empty = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'(st_in_if.ready), 32'd0);
        check("rst_out_valid", 32'(st_out_if.valid), 32'd0);
        check("rst_out_channel", 32'(st_out_if.channel), 32'd0);
        check("rst_readdata", csr_readdata, 32'd0);
        tick();
        reset_n = 1'b1;
        tick();
        check("ready_after_release", 32'(st_in_if.ready), 32'd1);

        // 3-beat packet on ch2, free-running output
        send_beat(4'd2, 1'b1, 1'b0, 5'd0);
        check("latency_out_valid", 32'(st_out_if.valid), 32'd1);
        send_beat(4'd2, 1'b0, 1'b0, 5'd0);
        send_beat(4'd2, 1'b0, 1'b1, 5'd4);
        idle(3);
        csr_rd(8'h18, 32'd1);
        csr_rd(8'h19, 32'd92);
        csr_rd(8'h1A, 32'd0);

        // same packet with backpressure
        csr_wr(CSR_CTRL, 32'd1);
        ready_mode = 0;
        idle(3);
        send_beat(4'd2, 1'b1, 1'b0, 5'd0);
        send_beat(4'd2, 1'b0, 1'b0, 5'd0);
        check("stall_ready_low", 32'(st_in_if.ready), 32'd0);
        ready_mode = 2;
        send_beat(4'd2, 1'b0, 1'b1, 5'd4);
        ready_mode = 1;
        idle(5);
        check("ready_recovered", 32'(st_in_if.ready), 32'd1);
        check("stall_no_beat_lost", 32'(exp_q.size()), 32'd0);
        csr_rd(8'h18, 32'd1);
        csr_rd(8'h19, 32'd92);
        csr_rd(8'h1A, 32'd0);

        // framing errors: SOP inside packet on ch1, stray non-SOP on ch0
        send_beat(4'd1, 1'b1, 1'b0, 5'd0);
        send_beat(4'd1, 1'b1, 1'b0, 5'd0);
        send_beat(4'd1, 1'b0, 1'b1, 5'd0);
        send_beat(4'd0, 1'b0, 1'b0, 5'd0);
        idle(3);
        csr_rd(8'h14, 32'd1);
        csr_rd(8'h15, 32'd96);
        csr_rd(8'h16, 32'd1);
        csr_rd(8'h10, 32'd0);
        csr_rd(8'h11, 32'd0);
        csr_rd(8'h12, 32'd1);

        // out-of-range channel
        csr_wr(CSR_CTRL, 32'd1);
        send_beat(4'd6, 1'b1, 1'b1, 5'd0);
        idle(3);
        csr_rd(CSR_BAD_CH, 32'd1);
        for (int c = 0; c < 4; c++)
            for (int o = 0; o < 3; o++)
                csr_rd(8'(8'h10 + 4 * c + o), 32'd0);

        // clear coincident with an EOP increment on ch0
        send_beat(4'd0, 1'b1, 1'b0, 5'd0);
        csr_address   = CSR_CTRL;
        csr_writedata = 32'd1;
        csr_write     = 1'b1;
        send_beat(4'd0, 1'b0, 1'b1, 5'd0);
        csr_write = 1'b0;
        idle(3);
        csr_rd(8'h10, 32'd0);
        csr_rd(8'h11, 32'd0);
        csr_rd(8'h12, 32'd0);
        csr_rd(8'h16, 32'd0);
        csr_rd(CSR_BAD_CH, 32'd0);
        csr_rd(8'h40, 32'hFFFF_FFFF);
        csr_rd(CSR_NCH, 32'd4);
        csr_rd(CSR_CTRL, 32'd0);

        // reset mid-packet
        send_beat(4'd3, 1'b1, 1'b0, 5'd0);
        #2;
        reset_n = 1'b0;
        st_in_if.valid = 1'b0;
        #1;
        check("async_rst_out_valid", 32'(st_out_if.valid), 32'd0);
        check("async_rst_in_ready", 32'(st_in_if.ready), 32'd0);
        exp_q.delete();
        tick();
        reset_n = 1'b1;
        send_beat(4'd3, 1'b1, 1'b0, 5'd0);
        send_beat(4'd3, 1'b0, 1'b1, 5'd0);
        idle(3);
        csr_rd(8'h1C, 32'd1);
        csr_rd(8'h1D, 32'd64);
        csr_rd(8'h1E, 32'd0);

        idle(4);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        check("csr_queue_drained", 32'(csr_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
